// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared definitions for the GRF hazard scheduler: forwarding select codes,
// Tuse/Tnew encodings, MDU latency defaults, producer record type and the
// Tnew ageing helper.
package grf_hazard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TIME_W = 2;
    localparam int unsigned SEL_W  = 2;

    // D-side operand selects
    localparam logic [SEL_W-1:0] FWD_GRF   = 2'd0;
    localparam logic [SEL_W-1:0] FWD_E     = 2'd1;
    localparam logic [SEL_W-1:0] FWD_M     = 2'd2;
    // E-side operand selects (0 = value already latched in the E register)
    localparam logic [SEL_W-1:0] FWD_E_REG = 2'd0;
    localparam logic [SEL_W-1:0] FWD_E_M   = 2'd1;
    localparam logic [SEL_W-1:0] FWD_W     = 2'd2;

    // Cycles until an operand is consumed, counted from D
    localparam logic [TIME_W-1:0] TUSE_D = 2'd0;
    localparam logic [TIME_W-1:0] TUSE_E = 2'd1;
    localparam logic [TIME_W-1:0] TUSE_M = 2'd2;

    // Cycles until a result exists, counted from entry into E
    localparam logic [TIME_W-1:0] TNEW_READY = 2'd0;
    localparam logic [TIME_W-1:0] TNEW_ALU   = 2'd1;
    localparam logic [TIME_W-1:0] TNEW_LOAD  = 2'd2;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // One pending GRF write as it moves down the pipe
    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic              we;
        logic [TIME_W-1:0] tnew;
    } prod_t;

    // Saturating one-stage ageing of a Tnew value
    function automatic logic [TIME_W-1:0] tnew_age(input logic [TIME_W-1:0] t);
        return (t == TNEW_READY) ? TNEW_READY : t - TIME_W'(1);
    endfunction

endpackage

// File: rtl/grf_hazard_cmp.sv
// Per-source hazard comparator. Checks one source register against a younger
// ("near") and an older ("far") producer record and returns a stall request
// and a forwarding select (0 = none, 1 = near, 2 = far; near wins).
// Forwarding and the Tnew/Tuse stall rule exist only when GRF_HAZARD_FWD_EN
// is defined; otherwise any pending write to the source stalls and the
// select stays 0.
//   src/src_used/tuse        source index, whether it is read, when it is read
//   near_*/far_*             producer records {a3, we, tnew}
//   stall                    source must wait
//   fwd_sel                  operand select
module grf_hazard_cmp
    import grf_hazard_ctrl_pkg::*;
#(
    // Far producer has its result already (W stage), ignore its Tnew for forwarding
    parameter bit FAR_ALWAYS_READY = 1'b0
) (
    input  logic [4:0] src,
    input  logic       src_used,
    input  logic [1:0] tuse,
    input  logic [4:0] near_a3,
    input  logic       near_we,
    input  logic [1:0] near_tnew,
    input  logic [4:0] far_a3,
    input  logic       far_we,
    input  logic [1:0] far_tnew,
    output logic       stall,
    output logic [1:0] fwd_sel
);

    logic near_match;
    logic far_match;

    // Writes to $0 never match because src is required to be nonzero
    always_comb begin
        near_match = (src != REG_W'(0)) && near_we && (near_a3 == src);
        far_match  = (src != REG_W'(0)) && far_we  && (far_a3  == src);
    end

`ifdef GRF_HAZARD_FWD_EN
    logic far_ready;
    assign far_ready = FAR_ALWAYS_READY || (far_tnew == TNEW_READY);

    always_comb begin
        stall   = src_used && ((near_match && (near_tnew > tuse)) ||
                               (far_match  && (far_tnew  > tuse)));
        fwd_sel = FWD_GRF;
        if (near_match && (near_tnew == TNEW_READY)) begin
            fwd_sel = 2'd1;
        end else if (far_match && far_ready) begin
            fwd_sel = 2'd2;
        end
    end
`else
    // Without forwarding the operand waits until the producer reaches W
    logic unused_timing;
    assign unused_timing = ^{tuse, near_tnew, far_tnew, FAR_ALWAYS_READY};

    always_comb begin
        stall   = src_used && (near_match || far_match);
        fwd_sel = FWD_GRF;
    end
`endif

endmodule

// File: rtl/grf_hazard_ctrl.sv
// GRF hazard scheduler for the 5-stage MIPS core. Keeps E/M/W producer
// records (Tnew scoreboard), raises the D-stage stall, generates D-side and
// E-side forwarding selects and times the mult/div busy window.
// Optional feature macro: GRF_HAZARD_FWD_EN (forwarding + Tnew/Tuse stall);
// undefined, all fwd_* are 0 and any pending E/M write to a source stalls.
//   clk, reset            clock, synchronous active-high reset
//   flush                 cancel instructions in E and M
//   rs_d/rt_d, *_use_d    D sources and whether they are read
//   *_tuse_d              when each source is needed
//   a3_d/we_d/tnew_d      D destination and its Tnew
//   md_d                  D instruction uses the MDU
//   md_start_e/md_div_e   E starts mult (0) or div (1)
//   stall                 freeze PC/D, bubble into E
//   fwd_rs_d/fwd_rt_d     D operand selects (0 GRF, 1 E, 2 M)
//   fwd_rs_e/fwd_rt_e     E operand selects (0 E reg, 1 M, 2 W)
//   md_busy               MDU busy
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       rs_use_d,
    input  logic       rt_use_d,
    input  logic [1:0] rs_tuse_d,
    input  logic [1:0] rt_tuse_d,
    input  logic [4:0] a3_d,
    input  logic       we_d,
    input  logic [1:0] tnew_d,
    input  logic       md_d,
    input  logic       md_start_e,
    input  logic       md_div_e,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    localparam int unsigned CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    prod_t             e_prod;
    prod_t             m_prod;
    prod_t             w_prod;
    logic [REG_W-1:0]  e_rs;
    logic [REG_W-1:0]  e_rt;
    logic [CNT_W-1:0]  md_cnt;

    logic              stall_rs;
    logic              stall_rt;
    logic [1:0]        e_stall_unused;

    // Producer records: W always takes M, flush beats stall for E and M
    always_ff @(posedge clk) begin
        if (reset) begin
            e_prod <= '0;
            m_prod <= '0;
            w_prod <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
        end else begin
            w_prod <= m_prod;
            if (flush) begin
                e_prod <= '0;
                m_prod <= '0;
                e_rs   <= '0;
                e_rt   <= '0;
            end else begin
                m_prod.a3   <= e_prod.a3;
                m_prod.we   <= e_prod.we;
                m_prod.tnew <= tnew_age(e_prod.tnew);
                if (stall) begin
                    e_prod <= '0;
                    e_rs   <= '0;
                    e_rt   <= '0;
                end else begin
                    e_prod.a3   <= a3_d;
                    e_prod.we   <= we_d;
                    e_prod.tnew <= tnew_d;
                    e_rs        <= rs_d;
                    e_rt        <= rt_d;
                end
            end
        end
    end

    // MDU busy counter; a start reloads it, flush leaves it running
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (md_start_e) begin
            md_cnt <= md_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign md_busy = md_start_e || (md_cnt != '0);

    // D sources against E (near) and M (far)
    grf_hazard_cmp #(.FAR_ALWAYS_READY(1'b0)) u_cmp_rs_d (
        .src       (rs_d),
        .src_used  (rs_use_d),
        .tuse      (rs_tuse_d),
        .near_a3   (e_prod.a3),
        .near_we   (e_prod.we),
        .near_tnew (e_prod.tnew),
        .far_a3    (m_prod.a3),
        .far_we    (m_prod.we),
        .far_tnew  (m_prod.tnew),
        .stall     (stall_rs),
        .fwd_sel   (fwd_rs_d)
    );

    grf_hazard_cmp #(.FAR_ALWAYS_READY(1'b0)) u_cmp_rt_d (
        .src       (rt_d),
        .src_used  (rt_use_d),
        .tuse      (rt_tuse_d),
        .near_a3   (e_prod.a3),
        .near_we   (e_prod.we),
        .near_tnew (e_prod.tnew),
        .far_a3    (m_prod.a3),
        .far_we    (m_prod.we),
        .far_tnew  (m_prod.tnew),
        .stall     (stall_rt),
        .fwd_sel   (fwd_rt_d)
    );

    // E sources against M (near) and W (far); only the selects are used
    grf_hazard_cmp #(.FAR_ALWAYS_READY(1'b1)) u_cmp_rs_e (
        .src       (e_rs),
        .src_used  (1'b1),
        .tuse      (TUSE_D),
        .near_a3   (m_prod.a3),
        .near_we   (m_prod.we),
        .near_tnew (m_prod.tnew),
        .far_a3    (w_prod.a3),
        .far_we    (w_prod.we),
        .far_tnew  (w_prod.tnew),
        .stall     (e_stall_unused[0]),
        .fwd_sel   (fwd_rs_e)
    );

    grf_hazard_cmp #(.FAR_ALWAYS_READY(1'b1)) u_cmp_rt_e (
        .src       (e_rt),
        .src_used  (1'b1),
        .tuse      (TUSE_D),
        .near_a3   (m_prod.a3),
        .near_we   (m_prod.we),
        .near_tnew (m_prod.tnew),
        .far_a3    (w_prod.a3),
        .far_we    (w_prod.we),
        .far_tnew  (w_prod.tnew),
        .stall     (e_stall_unused[1]),
        .fwd_sel   (fwd_rt_e)
    );

    assign stall = stall_rs || stall_rt || (md_d && md_busy);

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl: a table of per-cycle D-stage vectors
// with hand-computed expectations (both with and without GRF_HAZARD_FWD_EN),
// followed by hand-written MDU, flush and reset sequences.
module tb_grf_hazard_ctrl;

`ifdef GRF_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [4:0] rs_d, rt_d, a3_d;
    logic       rs_use_d, rt_use_d, we_d, md_d, md_start_e, md_div_e;
    logic [1:0] rs_tuse_d, rt_tuse_d, tnew_d;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    grf_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .rs_use_d   (rs_use_d),
        .rt_use_d   (rt_use_d),
        .rs_tuse_d  (rs_tuse_d),
        .rt_tuse_d  (rt_tuse_d),
        .a3_d       (a3_d),
        .we_d       (we_d),
        .tnew_d     (tnew_d),
        .md_d       (md_d),
        .md_start_e (md_start_e),
        .md_div_e   (md_div_e),
        .stall      (stall),
        .fwd_rs_d   (fwd_rs_d),
        .fwd_rt_d   (fwd_rt_d),
        .fwd_rs_e   (fwd_rs_e),
        .fwd_rt_e   (fwd_rt_e),
        .md_busy    (md_busy)
    );

    typedef struct {
        logic       fl;
        logic [4:0] rs;
        logic       ru;
        logic [1:0] rst;
        logic [4:0] rt;
        logic       tu;
        logic [1:0] rtt;
        logic [4:0] a3;
        logic       we;
        logic [1:0] tn;
        logic       stall_f;   // expected stall with forwarding
        logic       stall_n;   // expected stall without forwarding
        logic [1:0] frsd, frtd, frse, frte;  // expected selects with forwarding
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic fl, input logic [4:0] rs, input logic ru,
                       input logic [1:0] rst, input logic [4:0] rt, input logic tu,
                       input logic [1:0] rtt, input logic [4:0] a3, input logic we,
                       input logic [1:0] tn, input logic sf, input logic sn,
                       input logic [1:0] frsd, input logic [1:0] frtd,
                       input logic [1:0] frse, input logic [1:0] frte);
        vec_t v;
        v.fl = fl; v.rs = rs; v.ru = ru; v.rst = rst; v.rt = rt; v.tu = tu; v.rtt = rtt;
        v.a3 = a3; v.we = we; v.tn = tn; v.stall_f = sf; v.stall_n = sn;
        v.frsd = frsd; v.frtd = frtd; v.frse = frse; v.frte = frte;
        vq.push_back(v);
    endtask

    task automatic nop(input logic sf, input logic sn, input logic [1:0] frse,
                       input logic [1:0] frte);
        add(0, 0,0,0, 0,0,0, 0,0,0, sf, sn, 0, 0, frse, frte);
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic idle();
        flush = 0; rs_d = 0; rt_d = 0; rs_use_d = 0; rt_use_d = 0;
        rs_tuse_d = 0; rt_tuse_d = 0; a3_d = 0; we_d = 0; tnew_d = 0;
        md_d = 0; md_start_e = 0; md_div_e = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mfhi held in D while the MDU runs: busy/stall on the start cycle and
    // while the counter walks cyc..1, released at 0
    task automatic mdu_run(input logic div, input int cyc, input string nm);
        idle();
        md_d = 1; md_start_e = 1; md_div_e = div;
        @(negedge clk);
        chk({nm, " start busy"}, 2'(md_busy), 2'd1);
        chk({nm, " start stall"}, 2'(stall), 2'd1);
        tick();
        md_start_e = 0;
        for (int k = cyc; k >= 1; k--) begin
            @(negedge clk);
            chk($sformatf("%s busy cnt%0d", nm, k), 2'(md_busy), 2'd1);
            chk($sformatf("%s stall cnt%0d", nm, k), 2'(stall), 2'd1);
            tick();
        end
        @(negedge clk);
        chk({nm, " done busy"}, 2'(md_busy), 2'd0);
        chk({nm, " done stall"}, 2'(stall), 2'd0);
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // Reset state
        @(negedge clk);
        chk("rst stall", 2'(stall), 2'd0);
        chk("rst fwd_rs_d", fwd_rs_d, 2'd0);
        chk("rst fwd_rt_d", fwd_rt_d, 2'd0);
        chk("rst fwd_rs_e", fwd_rs_e, 2'd0);
        chk("rst fwd_rt_e", fwd_rt_e, 2'd0);
        chk("rst md_busy", 2'(md_busy), 2'd0);
        tick();

        //  fl  rs ru rst  rt tu rtt  a3 we tn  sf sn  frsd frtd frse frte
        // lw $8 then addu $10,$8,$9 (tuse 1)
        add(0,  0, 0, 0,   0, 0, 0,   8, 1, 2,  0, 0,  0, 0, 0, 0);
        add(0,  8, 1, 1,   9, 1, 1,  10, 1, 1,  1, 1,  0, 0, 0, 0);
        add(0,  8, 1, 1,   9, 1, 1,  10, 1, 1,  0, 1,  0, 0, 0, 0);
        nop(0, 0, 2, 0);                                  // addu in E takes $8 from W
        add(0, 10, 1, 0,   0, 0, 0,   0, 0, 0,  0, 0,  2, 0, 0, 0);  // $10 ready in M
        nop(0, 0, 2, 0);
        nop(0, 0, 0, 0);
        // addu $9 then beq on $9 (tuse 0)
        add(0,  0, 0, 0,   0, 0, 0,   9, 1, 1,  0, 0,  0, 0, 0, 0);
        add(0,  9, 1, 0,   0, 0, 0,   0, 0, 0,  1, 1,  0, 0, 0, 0);
        add(0,  9, 1, 0,   0, 0, 0,   0, 0, 0,  0, 1,  2, 0, 0, 0);
        nop(0, 0, 2, 0);
        nop(0, 0, 0, 0);
        // jal then jr $31
        add(0,  0, 0, 0,   0, 0, 0,  31, 1, 0,  0, 0,  0, 0, 0, 0);
        add(0, 31, 1, 0,  31, 1, 1,   0, 0, 0,  0, 1,  1, 1, 0, 0);
        nop(0, 0, 1, 1);
        nop(0, 0, 0, 0);
        // $0 producer and reader
        add(0,  0, 0, 0,   0, 0, 0,   0, 1, 0,  0, 0,  0, 0, 0, 0);
        add(0,  0, 1, 0,   0, 1, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0);
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // lw $8, then flush while the use stalls
        add(0,  0, 0, 0,   0, 0, 0,   8, 1, 2,  0, 0,  0, 0, 0, 0);
        add(1,  8, 1, 1,   0, 0, 0,  10, 1, 1,  1, 1,  0, 0, 0, 0);
        add(0,  8, 1, 1,   0, 0, 0,  10, 1, 1,  0, 0,  0, 0, 0, 0);
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // lw $7 reaches M with tnew 1, rt read at tuse 0, rs unused
        add(0,  0, 0, 0,   0, 0, 0,   7, 1, 2,  0, 0,  0, 0, 0, 0);
        nop(0, 0, 0, 0);
        add(0,  7, 0, 0,   7, 1, 0,   0, 0, 0,  1, 1,  0, 0, 0, 0);
        add(0,  7, 0, 0,   7, 1, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // unused source never stalls; E side waits for tnew_M 0
        add(0,  0, 0, 0,   0, 0, 0,   5, 1, 2,  0, 0,  0, 0, 0, 0);
        add(0,  5, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0);
        // two lui $4 back to back: youngest producer wins
        add(0,  0, 0, 0,   0, 0, 0,   4, 1, 0,  0, 0,  0, 0, 0, 0);
        add(0,  0, 0, 0,   0, 0, 0,   4, 1, 0,  0, 0,  0, 0, 0, 0);
        add(0,  4, 1, 0,   0, 0, 0,   0, 0, 0,  0, 1,  1, 0, 0, 0);
        nop(0, 0, 1, 0);
        nop(0, 0, 0, 0);
        nop(0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            idle();
            flush = vq[i].fl; rs_d = vq[i].rs; rs_use_d = vq[i].ru; rs_tuse_d = vq[i].rst;
            rt_d = vq[i].rt; rt_use_d = vq[i].tu; rt_tuse_d = vq[i].rtt;
            a3_d = vq[i].a3; we_d = vq[i].we; tnew_d = vq[i].tn;
            @(negedge clk);
            chk($sformatf("v%0d stall", i), 2'(stall),
                2'(FWD ? vq[i].stall_f : vq[i].stall_n));
            chk($sformatf("v%0d fwd_rs_d", i), fwd_rs_d, FWD ? vq[i].frsd : 2'd0);
            chk($sformatf("v%0d fwd_rt_d", i), fwd_rt_d, FWD ? vq[i].frtd : 2'd0);
            chk($sformatf("v%0d fwd_rs_e", i), fwd_rs_e, FWD ? vq[i].frse : 2'd0);
            chk($sformatf("v%0d fwd_rt_e", i), fwd_rt_e, FWD ? vq[i].frte : 2'd0);
            chk($sformatf("v%0d md_busy", i), 2'(md_busy), 2'd0);
            tick();
        end
        idle();

        mdu_run(1'b0, 5, "mult");
        mdu_run(1'b1, 10, "div");

        // flush leaves the count alone; a new start reloads it
        md_start_e = 1; md_div_e = 1;
        tick();                          // count 10
        md_start_e = 0; flush = 1;
        tick();                          // count 9
        flush = 0;
        @(negedge clk);
        chk("flush keeps mdu busy", 2'(md_busy), 2'd1);
        tick();                          // count 8
        md_start_e = 1; md_div_e = 0;
        tick();                          // reloaded to 5
        md_start_e = 0;
        repeat (4) tick();               // count 1
        @(negedge clk);
        chk("reload busy cnt1", 2'(md_busy), 2'd1);
        tick();
        @(negedge clk);
        chk("reload idle", 2'(md_busy), 2'd0);
        tick();

        // reset in the middle of a div with a load in E
        md_start_e = 1; md_div_e = 1; a3_d = 8; we_d = 1; tnew_d = 2;
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        rs_d = 8; rs_use_d = 1; rs_tuse_d = 0; md_d = 1;
        @(negedge clk);
        chk("reset mdu busy", 2'(md_busy), 2'd0);
        chk("reset records stall", 2'(stall), 2'd0);
        tick();
        idle();
        @(negedge clk);
        chk("reset mdu stays idle", 2'(md_busy), 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
